// File: rtl/ula_pkg.sv
// ----------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the registered ULA: opcode encodings, the FSM state
// type and the bit positions of the {N,Z,C,V} flag vector.
// ----------------------------------------------------------------------------
package ula_pkg;

    // Opcode encodings carried on the 3-bit seletor input
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Flag vector bit positions
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage : ula_pkg

// File: rtl/ula_comb.sv
// ----------------------------------------------------------------------------
// ula_comb
// Combinational W-bit datapath for the single-cycle opcodes (000..101).
// Shift opcodes are handled iteratively by the top level and return zero here.
// Ports:
//   a_i, b_i  [W-1:0]  operands
//   op_i      [2:0]    opcode
//   res_o     [W-1:0]  raw (wrapping) result
//   carry_o            add: carry out of bit W-1; sub: NOT borrow
//   ovf_o              signed overflow for add/sub, 0 otherwise
// ----------------------------------------------------------------------------
module ula_comb
    import ula_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   op_i,
    output logic [W-1:0] res_o,
    output logic         carry_o,
    output logic         ovf_o
);

    logic [W:0] add_s;
    logic [W:0] sub_s;

    // Subtraction as A + ~B + 1 so the top bit is directly NOT borrow
    assign add_s = {1'b0, a_i} + {1'b0, b_i};
    assign sub_s = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};

    // Opcode decode and flag generation
    always_comb begin
        res_o   = '0;
        carry_o = 1'b0;
        ovf_o   = 1'b0;
        case (op_i)
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_NOT:  res_o = ~a_i;
            OP_NAND: res_o = ~(a_i & b_i);
            OP_ADD: begin
                res_o   = add_s[W-1:0];
                carry_o = add_s[W];
                ovf_o   = (a_i[W-1] == b_i[W-1]) && (add_s[W-1] != a_i[W-1]);
            end
            OP_SUB: begin
                res_o   = sub_s[W-1:0];
                carry_o = sub_s[W];
                ovf_o   = (a_i[W-1] != b_i[W-1]) && (sub_s[W-1] != a_i[W-1]);
            end
            default: res_o = '0;
        endcase
    end

endmodule : ula_comb

// File: rtl/ula_param_seq.sv
// ----------------------------------------------------------------------------
// ula_param_seq
// Registered, handshaked ULA. Logic and add/sub ops complete at the accept
// edge; shifts by n = B[SHW-1:0] run one bit per cycle in EXEC. The result and
// flags {N,Z,C,V} are held in HOLD until the consumer takes them.
// Build option: define ULA_SAT_EN for unsigned saturating add/sub
// (C/V stay raw, N/Z follow the saturated value).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   A, B, seletor         operands and opcode
//   out_valid / out_ready result handshake (out_valid only in HOLD)
//   resultado, flags      registered result and {N,Z,C,V}
// ----------------------------------------------------------------------------
module ula_param_seq
    import ula_pkg::*;
#(
    parameter int W   = 8,
    parameter int SHW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [2:0]   seletor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] resultado,
    output logic [3:0]   flags
);

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    state_t         state_q, state_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic           dir_q, dir_d;      // 1 = logical right shift
    logic [W-1:0]   res_q, res_d;
    logic [3:0]     flags_q, flags_d;

    logic           accept_s;
    logic           is_shift_s;
    logic [SHW-1:0] n_s;
    logic [W-1:0]   alu_res_s;
    logic           alu_c_s;
    logic           alu_v_s;
    logic [W-1:0]   sat_res_s;
    logic [W-1:0]   sh_next_s;
    logic           sh_out_s;

    function automatic logic [3:0] mk_flags(input logic [W-1:0] r,
                                            input logic c, input logic v);
        logic [3:0] f;
        f        = 4'b0000;
        f[FLG_N] = r[W-1];
        f[FLG_Z] = (r == '0);
        f[FLG_C] = c;
        f[FLG_V] = v;
        return f;
    endfunction

    assign accept_s   = in_valid && (state_q == IDLE);
    assign is_shift_s = (seletor[2:1] == 2'b11);
    assign n_s        = B[SHW-1:0];

    ula_comb #(.W(W)) u_comb (
        .a_i     (A),
        .b_i     (B),
        .op_i    (seletor),
        .res_o   (alu_res_s),
        .carry_o (alu_c_s),
        .ovf_o   (alu_v_s)
    );

    // Optional unsigned saturation of add/sub results
    always_comb begin
        sat_res_s = alu_res_s;
`ifdef ULA_SAT_EN
        if ((seletor == OP_ADD) && alu_c_s) begin
            sat_res_s = '1;
        end else if ((seletor == OP_SUB) && !alu_c_s) begin
            sat_res_s = '0;
        end else begin
            sat_res_s = alu_res_s;
        end
`endif
    end

    // One-bit shift step and the bit leaving the register
    always_comb begin
        if (dir_q) begin
            sh_next_s = {1'b0, sh_q[W-1:1]};
            sh_out_s  = sh_q[0];
        end else begin
            sh_next_s = {sh_q[W-2:0], 1'b0};
            sh_out_s  = sh_q[W-1];
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = (is_shift_s && (n_s != '0)) ? EXEC : HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = HOLD;
                end else begin
                    state_d = EXEC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: decoded straight from the state register
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
    end

    // Datapath next-state: capture on accept, shift in EXEC, hold otherwise
    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    sh_d  = A;
                    cnt_d = n_s;
                    dir_d = seletor[0];
                    if (is_shift_s) begin
                        // n==0 completes immediately; otherwise result lands at the end of EXEC
                        if (n_s == '0) begin
                            res_d   = A;
                            flags_d = mk_flags(A, 1'b0, 1'b0);
                        end else begin
                            res_d   = res_q;
                        end
                    end else begin
                        res_d   = sat_res_s;
                        flags_d = mk_flags(sat_res_s, alu_c_s, alu_v_s);
                    end
                end else begin
                    sh_d = sh_q;
                end
            end
            EXEC: begin
                sh_d  = sh_next_s;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    res_d   = sh_next_s;
                    flags_d = mk_flags(sh_next_s, sh_out_s, 1'b0);
                end else begin
                    res_d   = res_q;
                end
            end
            HOLD:    res_d = res_q;
            default: res_d = res_q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            res_q   <= '0;
            flags_q <= 4'b0000;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign resultado = res_q;
    assign flags     = flags_q;

endmodule : ula_param_seq

// File: tb/tb_ula_param_seq.sv
// ----------------------------------------------------------------------------
// tb_ula_param_seq
// Self-checking bench for ula_param_seq (W=8): directed vectors, HOLD stalls,
// reset during EXEC and randomized operations against a behavioural model.
// ----------------------------------------------------------------------------
module tb_ula_param_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] seletor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] resultado;
    logic [3:0] flags;

    int compared = 0;
    int failed   = 0;

    ula_param_seq #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .seletor   (seletor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultado (resultado),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result, flags {N,Z,C,V} and latency from the opcode rules
    function automatic void model(input logic [2:0] op, input logic [7:0] a,
                                  input logic [7:0] b, output logic [7:0] r,
                                  output logic [3:0] f, output int lat);
        int   ua = int'(a);
        int   ub = int'(b);
        int   sa = int'($signed(a));
        int   sb = int'($signed(b));
        int   t;
        int   n  = int'(b[2:0]);
        logic c  = 1'b0;
        logic v  = 1'b0;
        lat = 1;
        r   = 8'h00;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = ~a;
            3'd3: r = ~(a & b);
            3'd4: begin
                t = ua + ub;
                r = t[7:0];
                c = (t > 255);
                v = ((sa + sb) > 127) || ((sa + sb) < -128);
`ifdef ULA_SAT_EN
                if (c) r = 8'hFF;
`endif
            end
            3'd5: begin
                t = ua - ub;
                r = t[7:0];
                c = (ua >= ub);
                v = ((sa - sb) > 127) || ((sa - sb) < -128);
`ifdef ULA_SAT_EN
                if (!c) r = 8'h00;
`endif
            end
            3'd6: begin
                r   = a << n;
                c   = (n > 0) ? a[8-n] : 1'b0;
                lat = n + 1;
            end
            default: begin
                r   = a >> n;
                c   = (n > 0) ? a[n-1] : 1'b0;
                lat = n + 1;
            end
        endcase
        f = {r[7], (r == 8'h00), c, v};
    endfunction

    // Issue one operation from IDLE (called #1 after an edge) and check it
    task automatic do_op(input string nm, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef,
                         input int el, input int stall);
        int lat;
        compared++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL %s in_ready_idle: got %b want 1", nm, in_ready);
        end
        A = a; B = b; seletor = op; in_valid = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0; A = 8'($urandom); B = 8'($urandom); seletor = 3'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        compared++;
        if (lat != el) begin
            failed++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, el);
        end
        compared++;
        if (resultado !== er) begin
            failed++;
            $display("FAIL %s resultado: got %h want %h", nm, resultado, er);
        end
        compared++;
        if (flags !== ef) begin
            failed++;
            $display("FAIL %s flags: got %b want %b", nm, flags, ef);
        end
        for (int i = 0; i < stall; i++) begin
            // operands offered while busy must be ignored
            in_valid = 1'b1; A = 8'($urandom); B = 8'($urandom); seletor = 3'($urandom);
            @(posedge clk); #1;
            compared++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || resultado !== er || flags !== ef) begin
                failed++;
                $display("FAIL %s stall%0d: got ov=%b ir=%b r=%h f=%b want ov=1 ir=0 r=%h f=%b",
                         nm, i, out_valid, in_ready, resultado, flags, er, ef);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failed++;
            $display("FAIL %s release: got ov=%b ir=%b want ov=0 ir=1", nm, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = 8'h00; B = 8'h00; seletor = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (resultado !== 8'h00 || flags !== 4'b0000 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: got r=%h f=%b ov=%b want r=00 f=0000 ov=0",
                     resultado, flags, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_release in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
`ifdef ULA_SAT_EN
        do_op("add_carry", 3'b100, 8'hF0, 8'h20, 8'hFF, 4'b1010, 1, 0);
`else
        do_op("add_carry", 3'b100, 8'hF0, 8'h20, 8'h10, 4'b0010, 1, 0);
`endif
        do_op("sub_equal", 3'b101, 8'h05, 8'h05, 8'h00, 4'b0110, 1, 0);
        do_op("sub_ovf",   3'b101, 8'h80, 8'h01, 8'h7F, 4'b0011, 1, 0);
        do_op("shl_3",     3'b110, 8'h81, 8'h03, 8'h08, 4'b0000, 4, 0);
        do_op("shr_1",     3'b111, 8'h81, 8'h01, 8'h40, 4'b0010, 2, 0);
        do_op("shr_0",     3'b111, 8'h81, 8'h00, 8'h81, 4'b1000, 1, 0);
        do_op("shr_hiB",   3'b111, 8'hF0, 8'h0B, 8'h1E, 4'b0000, 4, 0);
        do_op("not",       3'b010, 8'h0F, 8'h00, 8'hF0, 4'b1000, 1, 0);
        do_op("nand",      3'b011, 8'hFF, 8'hFF, 8'h00, 4'b0100, 1, 0);
        do_op("and",       3'b000, 8'hAA, 8'h0F, 8'h0A, 4'b0000, 1, 0);
        do_op("or",        3'b001, 8'h80, 8'h01, 8'h81, 4'b1000, 1, 0);
    endtask

    task automatic test_hold_stall();
        do_op("hold_add",  3'b100, 8'h10, 8'h22, 8'h32, 4'b0000, 1, 5);
        do_op("hold_shl",  3'b110, 8'h01, 8'h07, 8'h80, 4'b1000, 8, 5);
        // the offered ops during the stall must not have been captured
        @(posedge clk); #1;
        compared++;
        if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL hold_no_capture: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        logic [3:0] f;
        int         l;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] a = 8'($urandom);
            logic [7:0] b = 8'($urandom);
            model(3'b100, a, b, r, f, l);
            do_op("b2b_add", 3'b100, a, b, r, f, l, 0);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic [3:0] f;
        int         l;
        for (int k = 0; k < 60; k++) begin
            logic [2:0] op = 3'($urandom);
            logic [7:0] a  = 8'($urandom);
            logic [7:0] b  = 8'($urandom);
            model(op, a, b, r, f, l);
            do_op("random", op, a, b, r, f, l, $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_exec();
        do_op("pre_rst", 3'b001, 8'h5A, 8'h00, 8'h5A, 4'b0000, 1, 0);
        A = 8'hFF; B = 8'h07; seletor = 3'b111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (resultado !== 8'h00 || flags !== 4'b0000 || out_valid !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid_exec: got r=%h f=%b ov=%b want r=00 f=0000 ov=0",
                     resultado, flags, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            compared++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failed++;
                $display("FAIL rst_aborted c%0d: got ov=%b ir=%b want ov=0 ir=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule : tb_ula_param_seq
